// File: rtl/i2s_frame_scheduler.sv
// rtl/i2s_frame_scheduler.sv - test frame sequencer (header, payload ramp, counter, gap) with valid/ready output
module i2s_frame_scheduler #(
  parameter int DATA_WIDTH  = 24,
  parameter int PAYLOAD_LEN = 15,
  parameter int GAP_LEN     = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  frame_count,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  tlast,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent
);

  localparam int IW = $clog2(PAYLOAD_LEN + 6);
  localparam int GW = $clog2(GAP_LEN + 2);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_COUNT, S_GAP} state_t;

  state_t                r_state, w_state_n;
  logic [IW-1:0]         r_idx, w_idx_n;
  logic [GW-1:0]         r_gap, w_gap_n;
  logic [DATA_WIDTH-1:0] r_tdata, w_tdata_n;
  logic                  r_tvalid, w_tvalid_n;
  logic                  r_tlast, w_tlast_n;
  logic                  r_busy;
  logic                  r_done, w_done_n;
  logic [CNT_WIDTH-1:0]  r_frames_sent, w_fs_n;
  logic [CNT_WIDTH-1:0]  r_frame_count, w_fc_n;
  logic                  r_stop, w_stop_n;
  logic                  w_hs;
  logic                  w_decide;
  logic                  w_end;

  // Header words are left-justified into the sample word
  function automatic logic [DATA_WIDTH-1:0] hdr_word(input logic [2:0] idx);
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] w;
    case (idx)
      3'd0:    h = 16'h0B77;
      3'd1:    h = 16'hA1DD;
      3'd2:    h = 16'h4240;
      3'd3:    h = 16'h2F84;
      default: h = 16'h2B03;
    endcase
    w = '0;
    w[DATA_WIDTH-1 -: 16] = h;
    return w;
  endfunction

  assign w_hs = r_tvalid & tready;

  // Next-state and next-output logic; outputs only move on a handshake so stalls hold them
  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_gap_n    = r_gap;
    w_tdata_n  = r_tdata;
    w_tvalid_n = r_tvalid;
    w_tlast_n  = r_tlast;
    w_done_n   = 1'b0;
    w_fs_n     = r_frames_sent;
    w_fc_n     = r_frame_count;
    w_stop_n   = r_stop | (stop & (r_state != S_IDLE));
    w_decide   = 1'b0;
    w_end      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_fc_n     = frame_count;
          w_fs_n     = '0;
          w_state_n  = S_HEADER;
          w_idx_n    = '0;
          w_tvalid_n = 1'b1;
          w_tdata_n  = hdr_word(3'd0);
          w_tlast_n  = 1'b0;
        end
      end
      S_HEADER: begin
        if (w_hs) begin
          if (r_idx == IW'(4)) begin
            w_state_n = S_PAYLOAD;
            w_idx_n   = '0;
            w_tdata_n = DATA_WIDTH'(5);
          end else begin
            w_idx_n   = r_idx + 1'b1;
            w_tdata_n = hdr_word(r_idx[2:0] + 3'd1);
          end
        end
      end
      S_PAYLOAD: begin
        if (w_hs) begin
          if (r_idx == IW'(PAYLOAD_LEN - 1)) begin
            w_state_n = S_COUNT;
            w_tdata_n = DATA_WIDTH'(r_frames_sent);
            w_tlast_n = 1'b1;
          end else begin
            w_idx_n   = r_idx + 1'b1;
            w_tdata_n = DATA_WIDTH'(r_idx) + DATA_WIDTH'(6);
          end
        end
      end
      S_COUNT: begin
        if (w_hs) begin
          w_fs_n     = r_frames_sent + 1'b1;
          w_tvalid_n = 1'b0;
          w_tlast_n  = 1'b0;
          w_tdata_n  = '0;
          if (GAP_LEN == 0) begin
            w_decide = 1'b1;
          end else begin
            w_state_n = S_GAP;
            w_gap_n   = '0;
          end
        end
      end
      S_GAP: begin
        if (r_gap == GW'(GAP_LEN - 1)) w_decide = 1'b1;
        else                           w_gap_n  = r_gap + 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase

    // End-of-frame decision: a stop arriving in this very cycle also counts
    if (w_decide) begin
      w_end = r_stop | stop | ((r_frame_count != '0) && (w_fs_n == r_frame_count));
      if (w_end) begin
        w_state_n = S_IDLE;
        w_done_n  = 1'b1;
        w_stop_n  = 1'b0;
      end else begin
        w_state_n  = S_HEADER;
        w_idx_n    = '0;
        w_tvalid_n = 1'b1;
        w_tdata_n  = hdr_word(3'd0);
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_gap         <= '0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_frames_sent <= '0;
      r_frame_count <= '0;
      r_stop        <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_idx         <= w_idx_n;
      r_gap         <= w_gap_n;
      r_tdata       <= w_tdata_n;
      r_tvalid      <= w_tvalid_n;
      r_tlast       <= w_tlast_n;
      r_busy        <= (w_state_n != S_IDLE);
      r_done        <= w_done_n;
      r_frames_sent <= w_fs_n;
      r_frame_count <= w_fc_n;
      r_stop        <= w_stop_n;
    end
  end

  assign tdata       = r_tdata;
  assign tvalid      = r_tvalid;
  assign tlast       = r_tlast;
  assign busy        = r_busy;
  assign done        = r_done;
  assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// tb/tb_i2s_frame_scheduler.sv - randomized self-checking bench with behavioural frame model
module tb_i2s_frame_scheduler;
  localparam int DW = 24;
  localparam int PL = 15;
  localparam int GL = 4;
  localparam int CW = 16;
  localparam int FW = PL + 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          tready = 1'b1;
  logic [CW-1:0] frame_count = '0;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, busy, done;
  logic [CW-1:0] frames_sent;

  logic          start0 = 1'b0;
  logic          stop0 = 1'b0;
  logic          ready0 = 1'b1;
  logic [CW-1:0] fc0 = 16'd2;
  logic [DW-1:0] tdata_0;
  logic          tvalid_0, tlast_0, busy_0, done_0;
  logic [CW-1:0] frames_sent_0;

  int  checks = 0;
  int  errors = 0;
  int  hs_cnt = 0;
  int  done_cnt = 0;
  bit  chk_en = 1'b0;
  bit  ready_rand = 1'b0;

  int            m_pos = 0;
  bit            m_busy = 1'b0, m_done = 1'b0, m_stop = 1'b0;
  logic [CW-1:0] m_fs = '0, m_fc = '0;

  always #5 clk = ~clk;

  i2s_frame_scheduler #(.DATA_WIDTH(DW), .PAYLOAD_LEN(PL), .GAP_LEN(GL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .frame_count(frame_count),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  i2s_frame_scheduler #(.DATA_WIDTH(DW), .PAYLOAD_LEN(PL), .GAP_LEN(0), .CNT_WIDTH(CW)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop0), .frame_count(fc0),
    .tdata(tdata_0), .tvalid(tvalid_0), .tready(ready0), .tlast(tlast_0),
    .busy(busy_0), .done(done_0), .frames_sent(frames_sent_0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word at position pos of a frame: 5 header words, ramp 5..PL+4, then the counter
  function automatic logic [DW-1:0] exp_word(input int pos, input logic [CW-1:0] fs);
    logic [15:0] h;
    if (pos < 5) begin
      case (pos)
        0: h = 16'h0B77;
        1: h = 16'hA1DD;
        2: h = 16'h4240;
        3: h = 16'h2F84;
        default: h = 16'h2B03;
      endcase
      return {h, 8'h00};
    end else if (pos < FW - 1) begin
      return DW'(pos);
    end
    return DW'(fs);
  endfunction

  // Behavioural model: m_pos 0..FW-1 are frame words, FW.. are gap cycles
  always @(posedge clk) begin : model
    bit decide;
    decide = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_stop = 1'b0; m_fs = '0; m_pos = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy = 1'b1; m_fc = frame_count; m_fs = '0; m_pos = 0; m_stop = 1'b0;
        end
      end else begin
        if (stop) m_stop = 1'b1;
        if (m_pos < FW) begin
          if (tready) begin
            if (m_pos == FW - 1) begin
              m_fs = m_fs + 1'b1;
              m_pos = FW;
              if (GL == 0) decide = 1'b1;
            end else begin
              m_pos++;
            end
          end
        end else if (m_pos == FW + GL - 1) begin
          decide = 1'b1;
        end else begin
          m_pos++;
        end
        if (decide) begin
          if (m_stop || (m_fc != 0 && m_fs == m_fc)) begin
            m_busy = 1'b0; m_done = 1'b1; m_stop = 1'b0;
          end else begin
            m_pos = 0;
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("tvalid", 32'(tvalid), 32'(m_busy && m_pos < FW));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("frames_sent", 32'(frames_sent), 32'(m_fs));
      if (m_busy && m_pos < FW) begin
        check("tdata", 32'(tdata), 32'(exp_word(m_pos, m_fs)));
        check("tlast", 32'(tlast), 32'(m_pos == FW - 1));
      end
      if (tvalid && tready) hs_cnt++;
      if (done) done_cnt++;
    end
  end

  // Ready driver
  always @(posedge clk) begin
    #2 tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic pulse_start(input logic [CW-1:0] fc);
    @(posedge clk); #2;
    frame_count = fc; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #2 stop = 1'b1;
    @(posedge clk); #2 stop = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); n++;
    end
    if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_model(input int fs, input int pos, input int budget);
    int n = 0;
    while (!(m_fs == CW'(fs) && m_pos == pos && m_busy) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) check("wait_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int h0, d0, n;
    bit got;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_tlast", 32'(tlast), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_frames_sent", 32'(frames_sent), 0);
    chk_en = 1'b1;

    // 1: single frame, always ready
    h0 = hs_cnt; d0 = done_cnt;
    pulse_start(16'd1);
    @(negedge clk);
    check("t1_latency_tvalid", 32'(tvalid), 1);
    check("t1_first_word", 32'(tdata), 32'h0B7700);
    wait_done(d0 + 1, 200);
    check("t1_handshakes", 32'(hs_cnt - h0), 21);
    check("t1_dones", 32'(done_cnt - d0), 1);
    check("t1_frames_sent", 32'(frames_sent), 1);

    // 2: single frame with random stalls
    ready_rand = 1'b1;
    h0 = hs_cnt; d0 = done_cnt;
    pulse_start(16'd1);
    wait_done(d0 + 1, 500);
    check("t2_handshakes", 32'(hs_cnt - h0), 21);
    check("t2_frames_sent", 32'(frames_sent), 1);

    // 3: two frames, plus an ignored start while busy
    ready_rand = 1'b0;
    h0 = hs_cnt; d0 = done_cnt;
    pulse_start(16'd2);
    repeat (8) @(posedge clk);
    pulse_start(16'd5);
    wait_done(d0 + 1, 300);
    check("t3_handshakes", 32'(hs_cnt - h0), 42);
    check("t3_dones", 32'(done_cnt - d0), 1);
    check("t3_frames_sent", 32'(frames_sent), 2);

    // 4: continuous run stopped in frame 3 payload, then start+stop together
    ready_rand = 1'b1;
    d0 = done_cnt;
    pulse_start(16'd0);
    wait_model(2, 10, 2000);
    pulse_stop();
    wait_done(d0 + 1, 500);
    check("t4_frames_sent", 32'(frames_sent), 3);
    check("t4_dones", 32'(done_cnt - d0), 1);
    d0 = done_cnt;
    @(posedge clk); #2 start = 1'b1; stop = 1'b1;
    @(posedge clk); #2 start = 1'b0; stop = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_startstop_busy", 32'(busy), 0);
    check("t4_startstop_done", 32'(done_cnt - d0), 0);

    // 5: reset during header word 2, then a fresh run
    ready_rand = 1'b0;
    d0 = done_cnt;
    pulse_start(16'd1);
    wait_model(0, 1, 50);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("t5_tvalid", 32'(tvalid), 0);
    check("t5_tdata", 32'(tdata), 0);
    check("t5_tlast", 32'(tlast), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_frames_sent", 32'(frames_sent), 0);
    check("t5_no_done", 32'(done_cnt - d0), 0);
    h0 = hs_cnt;
    pulse_start(16'd1);
    wait_done(d0 + 1, 200);
    check("t5_handshakes", 32'(hs_cnt - h0), 21);
    check("t5_frames_sent_after", 32'(frames_sent), 1);

    // 6: GAP_LEN=0 build, header follows the counter word immediately
    @(posedge clk); #2 start0 = 1'b1;
    @(posedge clk); #2 start0 = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 200) begin
      @(negedge clk); n++;
      if (tvalid_0 && tlast_0) begin
        check("g0_counter_word", 32'(tdata_0), 0);
        @(negedge clk);
        check("g0_next_tvalid", 32'(tvalid_0), 1);
        check("g0_next_word", 32'(tdata_0), 32'h0B7700);
        got = 1'b1;
      end
    end
    if (!got) check("g0_timeout", 0, 1);
    n = 0;
    while (!done_0 && n < 200) begin
      @(negedge clk); n++;
    end
    check("g0_done", 32'(done_0), 1);
    check("g0_frames_sent", 32'(frames_sent_0), 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
